// File: rtl/wb_merge_pkg.sv
// Shared write-back definitions: register bus widths and boolean constants.
package wb_merge_pkg;

  localparam int RegAddrBus = 5;
  localparam int RegBus     = 32;

  localparam logic False_v = 1'b0;
  localparam logic True_v  = 1'b1;

  localparam logic [RegBus-1:0] ZeroWord = '0;

endpackage : wb_merge_pkg

// File: rtl/wb_merge_fifo.sv
// Per-channel write-back FIFO. Holds (address, data) pairs and exposes every
// stored address with a valid flag so the parent can look up pending writes.
module wb_fifo
  import wb_merge_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = RegAddrBus,
  parameter int DW    = RegBus
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [AW-1:0]       push_addr,
  input  logic [DW-1:0]       push_data,
  input  logic                pop,
  output logic                full,
  output logic                empty,
  output logic [AW-1:0]       head_addr,
  output logic [DW-1:0]       head_data,
  output logic [DEPTH*AW-1:0] ent_addr,
  output logic [DEPTH-1:0]    ent_valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] offs;

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign head_addr = addr_mem[rd_ptr_q];
  assign head_data = data_mem[rd_ptr_q];

  // Next pointer/count values; pointers wrap naturally at DEPTH.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage written at the write pointer.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset; count and pointers alone decide which entries are valid.
    if (do_push) begin
      addr_mem[wr_ptr_q] <= push_addr;
      data_mem[wr_ptr_q] <= push_data;
    end
  end

  // An entry is valid when its distance from the read pointer is below count.
  always_comb begin
    offs      = '0;
    ent_valid = '0;
    ent_addr  = '0;
    for (int j = 0; j < DEPTH; j++) begin
      offs                  = PW'(j) - rd_ptr_q;
      ent_valid[j]          = ({1'b0, offs} < count_q);
      ent_addr[j*AW +: AW]  = addr_mem[j];
    end
  end

endmodule : wb_fifo

// File: rtl/wb_merge.sv
// Multi-channel write-back merge: per-channel FIFOs drained by a round-robin
// arbiter into one registered register-file write port, with a pending-write
// lookup for decode interlocks.
module wb_merge
  import wb_merge_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int DEPTH = 2,
  parameter int AW    = RegAddrBus,
  parameter int DW    = RegBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [4:0]        stall,
  input  logic [NCH-1:0]    ch_we,
  input  logic [NCH*AW-1:0] ch_waddr,
  input  logic [NCH*DW-1:0] ch_wdata,
  output logic [NCH-1:0]    ch_ready,
  output logic              we_out,
  output logic [AW-1:0]     waddr_out,
  output logic [DW-1:0]     wdata_out,
  input  logic [AW-1:0]     pend_raddr,
  output logic              pend_hit
);

  localparam int RRW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]      push;
  logic [NCH-1:0]      pop;
  logic [NCH-1:0]      full;
  logic [NCH-1:0]      empty;
  logic [AW-1:0]       head_addr [NCH];
  logic [DW-1:0]       head_data [NCH];
  logic [DEPTH*AW-1:0] ent_addr  [NCH];
  logic [DEPTH-1:0]    ent_valid [NCH];

  logic [RRW-1:0] rr_ptr_q, rr_ptr_d;
  logic           we_out_q, we_out_d;
  logic [AW-1:0]  waddr_out_q, waddr_out_d;
  logic [DW-1:0]  wdata_out_q, wdata_out_d;

  logic           drain;
  logic           found;
  logic           grant;
  logic [RRW-1:0] win;
  int             idx;
  logic           hit;

  // Only stall[4] concerns write-back; the other stall bits belong to earlier stages.
  logic unused_stall;
  assign unused_stall = ^stall[3:0];

  // Readiness comes from registered occupancy only, never from ch_we.
  assign ch_ready = {NCH{rdy}} & ~full;
  assign drain    = rdy & ~stall[4];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    // Writes to x0 are acknowledged but never stored.
    assign push[i] = ch_we[i] & ch_ready[i] & (ch_waddr[i*AW +: AW] != '0);

    wb_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[i]),
      .push_addr (ch_waddr[i*AW +: AW]),
      .push_data (ch_wdata[i*DW +: DW]),
      .pop       (pop[i]),
      .full      (full[i]),
      .empty     (empty[i]),
      .head_addr (head_addr[i]),
      .head_data (head_data[i]),
      .ent_addr  (ent_addr[i]),
      .ent_valid (ent_valid[i])
    );
  end

  // Round-robin pick: first non-empty channel starting at rr_ptr, then next output/pointer state.
  always_comb begin
    found       = 1'b0;
    win         = '0;
    idx         = 0;
    pop         = '0;
    rr_ptr_d    = rr_ptr_q;
    we_out_d    = 1'b0;
    waddr_out_d = '0;
    wdata_out_d = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(rr_ptr_q) + k) % NCH;
      if (!found && !empty[idx]) begin
        found = 1'b1;
        win   = RRW'(idx);
      end
    end
    grant = drain & found;
    if (grant) begin
      pop[win]    = 1'b1;
      we_out_d    = 1'b1;
      waddr_out_d = head_addr[win];
      wdata_out_d = head_data[win];
      rr_ptr_d    = (win == RRW'(NCH - 1)) ? '0 : win + RRW'(1);
    end
  end

  // Arbiter pointer and registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      we_out_q    <= 1'b0;
      waddr_out_q <= '0;
      wdata_out_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      we_out_q    <= we_out_d;
      waddr_out_q <= waddr_out_d;
      wdata_out_q <= wdata_out_d;
    end
  end

  assign we_out    = we_out_q;
  assign waddr_out = waddr_out_q;
  assign wdata_out = wdata_out_q;

  // Pending lookup across every valid FIFO entry and the write port itself.
  always_comb begin
    hit = we_out_q && (waddr_out_q == pend_raddr);
    for (int i = 0; i < NCH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (ent_valid[i][j] && (ent_addr[i][j*AW +: AW] == pend_raddr)) hit = 1'b1;
      end
    end
    pend_hit = (pend_raddr != '0) && hit;
  end

endmodule : wb_merge

// File: tb/tb_wb_merge.sv
// Self-checking bench for wb_merge: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_wb_merge;

  localparam int NCH   = 2;
  localparam int DEPTH = 2;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              rdy;
  logic [4:0]        stall;
  logic [NCH-1:0]    ch_we;
  logic [NCH*AW-1:0] ch_waddr;
  logic [NCH*DW-1:0] ch_wdata;
  logic [NCH-1:0]    ch_ready;
  logic              we_out;
  logic [AW-1:0]     waddr_out;
  logic [DW-1:0]     wdata_out;
  logic [AW-1:0]     pend_raddr;
  logic              pend_hit;

  wb_merge #(.NCH(NCH), .DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .stall      (stall),
    .ch_we      (ch_we),
    .ch_waddr   (ch_waddr),
    .ch_wdata   (ch_wdata),
    .ch_ready   (ch_ready),
    .we_out     (we_out),
    .waddr_out  (waddr_out),
    .wdata_out  (wdata_out),
    .pend_raddr (pend_raddr),
    .pend_hit   (pend_hit)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq [NCH][$];
  int            m_rr;
  logic          m_we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  bit            m_ready_pre [NCH];
  bit            m_found;
  int            m_win;
  int            m_idx;
  ent_t          m_e;

  function automatic bit model_pend(input logic [AW-1:0] a);
    bit h;
    h = m_we && (m_waddr == a);
    for (int i = 0; i < NCH; i++)
      foreach (mq[i][j]) if (mq[i][j].a == a) h = 1'b1;
    return (a != '0) && h;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) mq[i].delete();
      m_rr = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
    end else begin
      for (int i = 0; i < NCH; i++) m_ready_pre[i] = rdy && (mq[i].size() < DEPTH);
      m_found = 1'b0;
      m_win   = 0;
      if (rdy && !stall[4]) begin
        for (int k = 0; k < NCH; k++) begin
          m_idx = (m_rr + k) % NCH;
          if (!m_found && mq[m_idx].size() > 0) begin
            m_found = 1'b1;
            m_win   = m_idx;
          end
        end
      end
      if (m_found) begin
        m_e     = mq[m_win].pop_front();
        m_we    = 1'b1;
        m_waddr = m_e.a;
        m_wdata = m_e.d;
        m_rr    = (m_win + 1) % NCH;
      end else begin
        m_we = 1'b0; m_waddr = '0; m_wdata = '0;
      end
      for (int i = 0; i < NCH; i++) begin
        if (m_ready_pre[i] && ch_we[i] && ch_waddr[i*AW +: AW] != '0) begin
          m_e.a = ch_waddr[i*AW +: AW];
          m_e.d = ch_wdata[i*DW +: DW];
          mq[i].push_back(m_e);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      logic [NCH-1:0] exp_ready;
      for (int i = 0; i < NCH; i++) exp_ready[i] = rdy && (mq[i].size() < DEPTH);
      check("ch_ready", 64'(ch_ready), 64'(exp_ready));
      check("we_out", 64'(we_out), 64'(m_we));
      check("waddr_out", 64'(waddr_out), 64'(m_waddr));
      check("wdata_out", 64'(wdata_out), 64'(m_wdata));
      check("pend_hit", 64'(pend_hit), 64'(model_pend(pend_raddr)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rdy = 1'b1; stall = '0; ch_we = '0; ch_waddr = '0; ch_wdata = '0; pend_raddr = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset then idle.
    pend_raddr = 5'd5;
    #1;
    check("rst_we", 64'(we_out), 64'd0);
    check("rst_waddr", 64'(waddr_out), 64'd0);
    check("rst_wdata", 64'(wdata_out), 64'd0);
    check("rst_ready", 64'(ch_ready), 64'h3);
    check("rst_pend5", 64'(pend_hit), 64'd0);

    // Single write on ch0.
    ch_we = 2'b01; ch_waddr = {5'd0, 5'd3}; ch_wdata = {32'd0, 32'hDEADBEEF}; pend_raddr = 5'd3;
    step();
    ch_we = '0;
    #1;
    check("single_pend_queued", 64'(pend_hit), 64'd1);
    check("single_we_early", 64'(we_out), 64'd0);
    step();
    check("single_we", 64'(we_out), 64'd1);
    check("single_waddr", 64'(waddr_out), 64'd3);
    check("single_wdata", 64'(wdata_out), 64'hDEADBEEF);
    check("single_pend_port", 64'(pend_hit), 64'd1);
    step();
    check("single_we_after", 64'(we_out), 64'd0);
    check("single_pend_after", 64'(pend_hit), 64'd0);

    // Contention and round-robin, filled under stall.
    do_reset();
    idle_inputs();
    stall = 5'b10000;
    ch_we = 2'b11; ch_waddr = {5'd4, 5'd1}; ch_wdata = {32'hA4, 32'hA1};
    step();
    ch_waddr = {5'd5, 5'd2}; ch_wdata = {32'hA5, 32'hA2};
    step();
    check("cont_full_ready", 64'(ch_ready), 64'h0);
    ch_we = 2'b01; ch_waddr = {5'd0, 5'd9}; ch_wdata = {32'd0, 32'hA9}; pend_raddr = 5'd9;
    step();
    check("cont_third_rejected", 64'(pend_hit), 64'd0);
    ch_we = '0; stall = '0;
    step(); check("rr_0", 64'(waddr_out), 64'd1);
    step(); check("rr_1", 64'(waddr_out), 64'd4);
    step(); check("rr_2", 64'(waddr_out), 64'd2);
    step(); check("rr_3", 64'(waddr_out), 64'd5);
    check("rr_3_data", 64'(wdata_out), 64'hA5);
    step(); check("rr_done", 64'(we_out), 64'd0);

    // Stall hold then release.
    do_reset();
    idle_inputs();
    stall = 5'b10000; pend_raddr = 5'd7;
    ch_we = 2'b10; ch_waddr = {5'd7, 5'd0}; ch_wdata = {32'h77, 32'd0};
    step();
    ch_we = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("stall_we", 64'(we_out), 64'd0);
      check("stall_pend", 64'(pend_hit), 64'd1);
    end
    stall = '0;
    step();
    check("stall_rel_we", 64'(we_out), 64'd1);
    check("stall_rel_addr", 64'(waddr_out), 64'd7);

    // Freeze with rdy low; a push attempted while frozen is ignored.
    do_reset();
    idle_inputs();
    stall = 5'b10000; pend_raddr = 5'd7;
    ch_we = 2'b10; ch_waddr = {5'd7, 5'd0}; ch_wdata = {32'h77, 32'd0};
    step();
    rdy = 1'b0; stall = '0; ch_we = 2'b01; ch_waddr = {5'd0, 5'd12};
    for (int c = 0; c < 3; c++) begin
      step();
      check("frz_ready", 64'(ch_ready), 64'h0);
      check("frz_we", 64'(we_out), 64'd0);
      check("frz_pend", 64'(pend_hit), 64'd1);
    end
    ch_we = '0; pend_raddr = 5'd12;
    #1;
    check("frz_push_dropped", 64'(pend_hit), 64'd0);
    rdy = 1'b1; pend_raddr = 5'd7;
    step();
    check("frz_rel_we", 64'(we_out), 64'd1);
    check("frz_rel_addr", 64'(waddr_out), 64'd7);

    // x0 writes are acknowledged but dropped.
    do_reset();
    idle_inputs();
    stall = 5'b10000;
    ch_we = 2'b01; ch_waddr = '0; ch_wdata = {32'd0, 32'h1234};
    step();
    ch_we = '0;
    #1;
    check("x0_ready", 64'(ch_ready), 64'h3);
    check("x0_pend", 64'(pend_hit), 64'd0);
    stall = '0;
    step();
    check("x0_we", 64'(we_out), 64'd0);
    step();
    check("x0_we2", 64'(we_out), 64'd0);

    // Reset mid-operation with both FIFOs full.
    idle_inputs();
    stall = 5'b10000;
    ch_we = 2'b11; ch_waddr = {5'd10, 5'd11}; ch_wdata = {32'h10, 32'h11};
    step();
    step();
    ch_we = '0; stall = '0; pend_raddr = 5'd11;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_ready", 64'(ch_ready), 64'h3);
    check("mid_rst_we", 64'(we_out), 64'd0);
    check("mid_rst_pend", 64'(pend_hit), 64'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("mid_rst_no_stale", 64'(we_out), 64'd0);
    end

    // Randomized traffic; the per-cycle compare does the checking.
    for (int c = 0; c < 4000; c++) begin
      rst        = ($urandom_range(0, 299) == 0);
      rdy        = ($urandom_range(0, 9) != 0);
      stall      = 5'($urandom);
      stall[4]   = ($urandom_range(0, 3) == 0);
      ch_we      = NCH'($urandom);
      for (int i = 0; i < NCH; i++) begin
        ch_waddr[i*AW +: AW] = AW'($urandom_range(0, 7));
        ch_wdata[i*DW +: DW] = $urandom;
      end
      pend_raddr = AW'($urandom_range(0, 7));
      step();
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_wb_merge
